// File: rtl/a_rom_loader_if.sv
// Byte-stream input and register-file write port of the A-coefficient loader.
// The master side is the host (drives bytes, observes the write port).
// The slave side is the loader (accepts bytes, drives the write port).
interface a_rom_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 14,
  parameter int IN_W   = 8
) ();

  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_en;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  w_addr,
    input  w_data,
    input  w_en
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output w_addr,
    output w_data,
    output w_en
  );

endinterface

// File: rtl/a_rom_loader.sv
// Writer-side front end for the 16 x 14-bit A-coefficient register file.
// Packs byte pairs from a valid/ready stream into coefficients, writes them
// to addresses 0..DEPTH-1 and reports completion and a running checksum.
module a_rom_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 14,
  parameter int IN_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  a_rom_loader_if.slave     bus,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_FIN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam int                HI_BITS   = DATA_W - 8;

  // Low byte in [7:0], low HI_BITS bits of the high byte above it; the rest
  // of the high byte is dropped.
  function automatic logic [DATA_W-1:0] pack_word(
    input logic [IN_W-1:0] lo_byte,
    input logic [IN_W-1:0] hi_byte
  );
    pack_word = {hi_byte[HI_BITS-1:0], lo_byte[7:0]};
  endfunction

  // Checksum is a plain modulo-2^DATA_W sum; the carry is discarded.
  function automatic logic [DATA_W-1:0] csum_add(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] word
  );
    csum_add = acc + word;
  endfunction

  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] cnt_q,      cnt_d;
  logic [IN_W-1:0]   lo_q,       lo_d;
  logic [ADDR_W-1:0] w_addr_q,   w_addr_d;
  logic [DATA_W-1:0] w_data_q,   w_data_d;
  logic              w_en_q,     w_en_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic [DATA_W-1:0] csum_q,     csum_d;

  logic              xfer;
  logic [DATA_W-1:0] word;

  // High-byte bits beyond the coefficient width are intentionally ignored.
  generate
    if (IN_W > HI_BITS) begin : g_hi_discard
      logic unused_in_hi;
      assign unused_in_hi = ^bus.in_data[IN_W-1:HI_BITS];
    end
  endgenerate

  assign xfer = bus.in_valid && in_ready_q;
  assign word = pack_word(lo_q, bus.in_data);

  // Next-state, datapath and registered-output decode for the load sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    w_en_d   = 1'b0;
    csum_d   = csum_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LO;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end
      S_LO: begin
        if (xfer) begin
          lo_d    = bus.in_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          w_data_d = word;
          w_addr_d = cnt_q;
          w_en_d   = 1'b1;
          csum_d   = csum_add(csum_q, word);
          if (cnt_q == LAST_ADDR) begin
            state_d = S_FIN;
          end else begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = S_LO;
          end
        end
      end
      S_FIN: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are decoded from the next state so they line up with it.
    in_ready_d = (state_d == S_LO) || (state_d == S_HI);
    busy_d     = (state_d == S_LO) || (state_d == S_HI) || (state_d == S_FIN);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lo_q       <= '0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      w_en_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lo_q       <= lo_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      w_en_q     <= w_en_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      csum_q     <= csum_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.w_data   = w_data_q;
  assign bus.w_en     = w_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign checksum     = csum_q;

endmodule

// File: tb/tb_a_rom_loader.sv
// Directed bench for a_rom_loader: sequential load, max-value packing,
// input gaps, start while busy, reset mid-load and idle/done valid.
module tb_a_rom_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [13:0] checksum;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [3:0]  wa[$];
  logic [13:0] wd[$];
  int          wc[$];

  a_rom_loader_if #(.ADDR_W(4), .DATA_W(14), .IN_W(8)) bus ();

  a_rom_loader #(.DEPTH(16), .ADDR_W(4), .DATA_W(14), .IN_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus.slave),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-port monitor, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (bus.w_en === 1'b1) begin
      wa.push_back(bus.w_addr);
      wd.push_back(bus.w_data);
      wc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      tests++; fails++;
      $display("FAIL send_byte_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] lo, input logic [7:0] hi, input int gap);
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    send_byte(lo);
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    send_byte(hi);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    tests++; if (bus.w_en !== 1'b0) begin fails++; $display("FAIL rst_w_en got=%b exp=0", bus.w_en); end
    tests++; if (bus.w_addr !== 4'd0) begin fails++; $display("FAIL rst_w_addr got=%0d exp=0", bus.w_addr); end
    tests++; if (bus.w_data !== 14'd0) begin fails++; $display("FAIL rst_w_data got=%h exp=0", bus.w_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got=%b exp=0", done); end
    tests++; if (checksum !== 14'd0) begin fails++; $display("FAIL rst_checksum got=%h exp=0", checksum); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_idle_valid();
    clear_log();
    bus.in_valid = 1'b1; bus.in_data = 8'h55;
    repeat (4) @(negedge clk);
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL idle_in_ready got=%b exp=0", bus.in_ready); end
    tests++; if (wa.size() != 0) begin fails++; $display("FAIL idle_writes got=%0d exp=0", wa.size()); end
    tests++; if (bus.w_addr !== 4'd0 || bus.w_data !== 14'd0) begin fails++; $display("FAIL idle_outputs got=%0d/%h exp=0/0", bus.w_addr, bus.w_data); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL idle_flags got=%b%b exp=00", busy, done); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_sequential();
    pulse_start();
    tests++; if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL seq_start got=%b%b exp=11", bus.in_ready, busy); end
    clear_log();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i + 1));
      send_byte(8'h00);
    end
    // FIN cycle: last write visible, loader no longer accepting
    tests++; if (bus.w_en !== 1'b1) begin fails++; $display("FAIL seq_fin_w_en got=%b exp=1", bus.w_en); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL seq_fin_in_ready got=%b exp=0", bus.in_ready); end
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL seq_fin_flags got=%b%b exp=10", busy, done); end
    @(negedge clk);
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL seq_done_flags got=%b%b exp=01", done, busy); end
    tests++; if (bus.w_en !== 1'b0) begin fails++; $display("FAIL seq_done_w_en got=%b exp=0", bus.w_en); end
    tests++; if (checksum !== 14'd136) begin fails++; $display("FAIL seq_checksum got=%0d exp=136", checksum); end
    tests++; if (wa.size() != 16) begin fails++; $display("FAIL seq_write_count got=%0d exp=16", wa.size()); end
    for (int k = 0; k < 16 && k < wa.size(); k++) begin
      tests++; if (wa[k] !== 4'(k) || wd[k] !== 14'(k + 1)) begin fails++; $display("FAIL seq_word%0d got=%0d/%h exp=%0d/%h", k, wa[k], wd[k], k, k + 1); end
      if (k > 0) begin
        tests++; if (wc[k] - wc[k-1] != 2) begin fails++; $display("FAIL seq_spacing%0d got=%0d exp=2", k, wc[k] - wc[k-1]); end
      end
    end
    // valid held high in DONE with no start: nothing moves
    repeat (3) @(negedge clk);
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL done_in_ready got=%b exp=0", bus.in_ready); end
    tests++; if (wa.size() != 16) begin fails++; $display("FAIL done_writes got=%0d exp=16", wa.size()); end
    tests++; if (done !== 1'b1 || checksum !== 14'd136) begin fails++; $display("FAIL done_hold got=%b/%0d exp=1/136", done, checksum); end
    tests++; if (bus.w_addr !== 4'd15 || bus.w_data !== 14'd16) begin fails++; $display("FAIL done_outputs got=%0d/%0d exp=15/16", bus.w_addr, bus.w_data); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_max_value();
    pulse_start();
    clear_log();
    for (int i = 0; i < 16; i++) send_word(8'hFF, 8'hFF, 0);
    bus.in_valid = 1'b0;
    tests++; if (bus.w_data !== 14'h3FFF) begin fails++; $display("FAIL max_w_data got=%h exp=3fff", bus.w_data); end
    @(negedge clk);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL max_done got=%b exp=1", done); end
    tests++; if (checksum !== 14'h3FF0) begin fails++; $display("FAIL max_checksum got=%h exp=3ff0", checksum); end
    tests++; if (wd.size() != 16) begin fails++; $display("FAIL max_write_count got=%0d exp=16", wd.size()); end
    for (int k = 0; k < wd.size(); k++) begin
      tests++; if (wd[k] !== 14'h3FFF) begin fails++; $display("FAIL max_word%0d got=%h exp=3fff", k, wd[k]); end
    end
  endtask

  task automatic test_gaps();
    int          gaps[16] = '{0, 3, 1, 5, 2, 0, 4, 1, 5, 0, 2, 3, 1, 4, 0, 2};
    logic [7:0]  lo, hi;
    logic [13:0] exp_w[16];
    logic [13:0] exp_sum;
    exp_sum = '0;
    pulse_start();
    clear_log();
    for (int i = 0; i < 16; i++) begin
      lo = 8'(i * 17 + 3);
      hi = 8'(i * 29 + 197);
      exp_w[i] = {hi[5:0], lo};
      exp_sum  = exp_sum + exp_w[i];
      send_word(lo, hi, gaps[i]);
    end
    bus.in_valid = 1'b0;
    tests++; if (bus.in_ready !== 1'b0 || bus.w_en !== 1'b1) begin fails++; $display("FAIL gap_fin got=%b%b exp=01", bus.in_ready, bus.w_en); end
    @(negedge clk);
    tests++; if (bus.in_ready !== 1'b0 || done !== 1'b1) begin fails++; $display("FAIL gap_done got=%b%b exp=01", bus.in_ready, done); end
    tests++; if (checksum !== exp_sum) begin fails++; $display("FAIL gap_checksum got=%h exp=%h", checksum, exp_sum); end
    tests++; if (wa.size() != 16) begin fails++; $display("FAIL gap_write_count got=%0d exp=16", wa.size()); end
    for (int k = 0; k < 16 && k < wa.size(); k++) begin
      tests++; if (wa[k] !== 4'(k) || wd[k] !== exp_w[k]) begin fails++; $display("FAIL gap_word%0d got=%0d/%h exp=%0d/%h", k, wa[k], wd[k], k, exp_w[k]); end
    end
  endtask

  task automatic test_start_busy();
    logic [13:0] exp_sum;
    exp_sum = '0;
    pulse_start();
    clear_log();
    for (int i = 0; i < 16; i++) begin
      if (i == 7) start = 1'b1;
      send_byte(8'(8'h40 + i));
      start = 1'b0;
      send_byte(8'(i));
      exp_sum = exp_sum + {6'(i), 8'(8'h40 + i)};
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL busy_start_done got=%b exp=1", done); end
    tests++; if (checksum !== exp_sum) begin fails++; $display("FAIL busy_start_checksum got=%h exp=%h", checksum, exp_sum); end
    tests++; if (wa.size() != 16) begin fails++; $display("FAIL busy_start_count got=%0d exp=16", wa.size()); end
    for (int k = 0; k < 16 && k < wa.size(); k++) begin
      tests++; if (wa[k] !== 4'(k)) begin fails++; $display("FAIL busy_start_addr%0d got=%0d exp=%0d", k, wa[k], k); end
    end
    // restart from DONE
    pulse_start();
    tests++; if (done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL restart_flags got=%b%b exp=01", done, busy); end
    tests++; if (checksum !== 14'd0) begin fails++; $display("FAIL restart_checksum got=%h exp=0", checksum); end
    clear_log();
    send_word(8'h34, 8'h12, 0);
    bus.in_valid = 1'b0;
    tests++; if (bus.w_en !== 1'b1 || bus.w_addr !== 4'd0 || bus.w_data !== 14'h1234) begin fails++; $display("FAIL restart_word got=%b/%0d/%h exp=1/0/1234", bus.w_en, bus.w_addr, bus.w_data); end
    tests++; if (checksum !== 14'h1234) begin fails++; $display("FAIL restart_sum got=%h exp=1234", checksum); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    clear_log();
    for (int i = 0; i < 5; i++) send_word(8'(i + 1), 8'h00, 0);
    send_byte(8'h66);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (bus.in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mid_rst_flags got=%b%b%b exp=000", bus.in_ready, busy, done); end
    tests++; if (bus.w_en !== 1'b0 || bus.w_addr !== 4'd0 || bus.w_data !== 14'd0) begin fails++; $display("FAIL mid_rst_bus got=%b/%0d/%h exp=0/0/0", bus.w_en, bus.w_addr, bus.w_data); end
    tests++; if (checksum !== 14'd0) begin fails++; $display("FAIL mid_rst_checksum got=%h exp=0", checksum); end
    @(negedge clk);
    tests++; if (wa.size() != 5) begin fails++; $display("FAIL mid_rst_writes got=%0d exp=5", wa.size()); end
    pulse_start();
    send_word(8'h77, 8'h01, 0);
    bus.in_valid = 1'b0;
    tests++; if (bus.w_addr !== 4'd0 || bus.w_data !== 14'h0177) begin fails++; $display("FAIL mid_reload got=%0d/%h exp=0/0177", bus.w_addr, bus.w_data); end
    tests++; if (checksum !== 14'h0177) begin fails++; $display("FAIL mid_reload_sum got=%h exp=0177", checksum); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_idle_valid();
    test_sequential();
    test_max_value();
    test_gaps();
    test_start_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/a_rom_loader.md
Name: a_rom_loader

Overview:
- Writer-side front end for the 16-entry x 14-bit A-coefficient register file.
- Accepts a byte stream from the host/input interface over a valid/ready handshake and packs each byte pair into one 14-bit coefficient.
- Writes the coefficients to sequential addresses 0..DEPTH-1, drives the register file's write address/data/enable, and reports completion plus a running checksum.

Parameters:
- DEPTH, 16, number of coefficient words per load.
- ADDR_W, 4, write address width; must satisfy 2^ADDR_W >= DEPTH.
- DATA_W, 14, coefficient width; must satisfy 8 < DATA_W <= 16.
- IN_W, 8, input byte width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle load request; honoured only in IDLE or DONE.
- in_data  in  IN_W  input byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- w_addr  out  ADDR_W  register-file write address.
- w_data  out  DATA_W  register-file write data.
- w_en  out  1  write strobe, one cycle per word.
- busy  out  1  load in progress.
- done  out  1  all DEPTH words written; held until the next start or rst.
- checksum  out  DATA_W  modulo-2^DATA_W sum of the words written in the current load.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst). Reset is sampled only on the clk rising edge.
- Reset values: state=IDLE, in_ready=0, w_addr=0, w_data=0, w_en=0, busy=0, done=0, checksum=0, byte-pair holding register=0.
- Handshake: a byte transfers on a rising edge where in_valid && in_ready. in_ready is a registered decode of state: 1 in LO and HI, 0 otherwise. in_data is ignored when no transfer occurs.
- Packing:
  - First byte of a pair supplies word[7:0].
  - Second byte bits [DATA_W-9:0] supply word[DATA_W-1:8]; its remaining upper bits are discarded.
- States:
  - IDLE: start moves to LO; clears the address counter and checksum.
  - LO: low-byte transfer latches the byte and moves to HI. Without a transfer, stays in LO.
  - HI: high-byte transfer does the following on that edge:
    - registers w_data = packed word and w_addr = counter;
    - sets w_en=1 for exactly the next cycle;
    - adds the word into checksum;
    - if counter == DEPTH-1, moves to FIN; otherwise increments the counter and moves to LO.
  - FIN: one cycle, with in_ready=0 (the last w_en is visible in this cycle). Unconditionally moves to DONE.
  - DONE: done=1, busy=0. start moves to LO, clears done, the counter and checksum.
- busy is 1 in LO, HI and FIN.
- Latency:
  - High-byte transfer at edge N -> w_en/w_addr/w_data valid from edge N until edge N+1.
  - Final word at edge N -> FIN during N..N+1, done=1 from edge N+1.
- Outputs between writes: w_addr and w_data hold their last values while w_en=0. The register file may re-sample them, and rewriting the same value is harmless.
- start while busy: ignored. The load continues, and the counter and checksum are not disturbed.
- Back-to-back bytes: in_valid held high gives one word per 2 cycles. Peak throughput is DEPTH words in 2*DEPTH+1 cycles from first transfer to done.
- Stalls: in_valid low in LO or HI holds the state, holding register, counter and checksum indefinitely.
- Reset mid-load: returns to IDLE with all reset values. A partially written word is dropped; no write is issued.
- Counter wrap: no wrap occurs. The counter never advances beyond DEPTH-1 within a load.
- Checksum arithmetic: wraps modulo 2^DATA_W with no carry out.

Test Plan:
- Reset, then pulse start with in_valid held high and bytes 0x01,0x00,0x02,0x00,...,0x10,0x00 -> 16 w_en pulses, one every 2 cycles, w_addr 0..15, w_data 1..16; done=1 one cycle after the last w_en; checksum=136 (0x088).
- Byte pair 0xFF,0xFF -> w_data=0x3FFF (upper two bits of the second byte dropped). All 16 words 0x3FFF -> checksum = (16*0x3FFF) mod 2^14 = 0x3FF0.
- Random in_valid gaps of 0-5 cycles during a load -> exact data/address sequence unchanged, no extra or missing w_en, in_ready=0 in FIN and DONE.
- start pulsed at word 7 mid-load -> ignored, load completes normally with w_addr 0..15. A second start in DONE -> done clears next cycle, w_addr restarts at 0, checksum restarts from 0.
- rst asserted after a low byte of word 5 -> next cycle state IDLE, all outputs at reset values, no w_en for word 5. A new start reloads from address 0.
- in_valid high while in IDLE or DONE with no start -> in_ready=0, no transfer, no w_en, outputs stable.
